// File: rtl/complex_pair_merge.sv
// Complex-product merge stage: forms Re = X - Y and Im = X + Y over two input beats,
// then holds the complex result vector under a valid/ready handshake.
module complex_pair_merge #(
    parameter int unsigned WORD_LEN   = 16,
    parameter int unsigned MATRIX_DIM = 4,
    parameter int unsigned CNT_LEN    = 8,
    parameter logic        REAL_SET   = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    output logic                                  state,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [MATRIX_DIM*2*WORD_LEN-1:0]      P_X,
    input  logic [MATRIX_DIM*2*WORD_LEN-1:0]      P_Y,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [MATRIX_DIM*(2*WORD_LEN+1)-1:0]  RE_OUT,
    output logic [MATRIX_DIM*(2*WORD_LEN+1)-1:0]  IM_OUT,
    output logic [CNT_LEN-1:0]                    res_cnt
);

    localparam int unsigned PROD_LEN = 2 * WORD_LEN;
    localparam int unsigned RES_LEN  = PROD_LEN + 1;

    typedef enum logic [1:0] {
        S_REAL,
        S_IMAG,
        S_OUT
    } fsm_t;

    fsm_t fsm, fsm_nxt;
    logic accept;
    logic [MATRIX_DIM*RES_LEN-1:0] diff, sum;

    assign in_ready = (fsm != S_OUT);
    assign accept   = in_valid && in_ready && !clr;

    always_comb begin
        fsm_nxt = fsm;
        if (clr) begin
            fsm_nxt = S_REAL;
        end else begin
            case (fsm)
                S_REAL:  if (accept)    fsm_nxt = S_IMAG;
                S_IMAG:  if (accept)    fsm_nxt = S_OUT;
                S_OUT:   if (out_ready) fsm_nxt = S_REAL;
                default:                fsm_nxt = S_REAL;
            endcase
        end
    end

    // One-bit sign extension keeps every sum/difference exact.
    always_comb begin
        diff = '0;
        sum  = '0;
        for (int unsigned k = 0; k < MATRIX_DIM; k++) begin
            diff[k*RES_LEN +: RES_LEN] =
                {P_X[k*PROD_LEN + PROD_LEN - 1], P_X[k*PROD_LEN +: PROD_LEN]} -
                {P_Y[k*PROD_LEN + PROD_LEN - 1], P_Y[k*PROD_LEN +: PROD_LEN]};
            sum[k*RES_LEN +: RES_LEN] =
                {P_X[k*PROD_LEN + PROD_LEN - 1], P_X[k*PROD_LEN +: PROD_LEN]} +
                {P_Y[k*PROD_LEN + PROD_LEN - 1], P_Y[k*PROD_LEN +: PROD_LEN]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= S_REAL;
            state     <= REAL_SET;
            out_valid <= 1'b0;
            res_cnt   <= '0;
        end else begin
            fsm       <= fsm_nxt;
            state     <= (fsm_nxt == S_REAL) ? REAL_SET : ~REAL_SET;
            out_valid <= (fsm_nxt == S_OUT);
            if (!clr && fsm == S_OUT && out_ready)
                res_cnt <= res_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RE_OUT <= '0;
            IM_OUT <= '0;
        end else if (accept) begin
            if (fsm == S_REAL)
                RE_OUT <= diff;
            else
                IM_OUT <= sum;
        end
    end

endmodule

// File: tb/tb_complex_pair_merge.sv
// Directed bench for complex_pair_merge with a pass-level reference model and a per-cycle compare.
module tb_complex_pair_merge;

    localparam int WL = 16;
    localparam int MD = 4;
    localparam int PL = 2 * WL;
    localparam int EL = PL + 1;

    logic clk = 1'b0;
    logic rst_n, clr, in_valid, out_ready;
    logic state, in_ready, out_valid;
    logic [MD*PL-1:0] px, py;
    logic [MD*EL-1:0] re_out, im_out;
    logic [7:0] res_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Pass-level reference: which beat is expected next, the last results, the handshake count.
    int    m_beat;
    bit    m_valid;
    int    m_cnt;
    longint m_re [MD];
    longint m_im [MD];

    complex_pair_merge #(
        .WORD_LEN(WL),
        .MATRIX_DIM(MD),
        .CNT_LEN(8),
        .REAL_SET(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .state(state),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .P_X(px),
        .P_Y(py),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .RE_OUT(re_out),
        .IM_OUT(im_out),
        .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    function automatic longint prod(input logic [MD*PL-1:0] v, input int k);
        logic [PL-1:0] e;
        e = v[k*PL +: PL];
        return longint'($signed(e));
    endfunction

    function automatic longint res(input logic [MD*EL-1:0] v, input int k);
        logic [EL-1:0] e;
        e = v[k*EL +: EL];
        return longint'($signed(e));
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_beat = 0; m_valid = 0; m_cnt = 0;
            for (int k = 0; k < MD; k++) begin m_re[k] = 0; m_im[k] = 0; end
        end else if (clr) begin
            m_beat = 0; m_valid = 0;
        end else if (m_beat == 0 && in_valid) begin
            for (int k = 0; k < MD; k++) m_re[k] = prod(px, k) - prod(py, k);
            m_beat = 1;
        end else if (m_beat == 1 && in_valid) begin
            for (int k = 0; k < MD; k++) m_im[k] = prod(px, k) + prod(py, k);
            m_beat = 2; m_valid = 1;
        end else if (m_beat == 2 && out_ready) begin
            m_beat = 0; m_valid = 0; m_cnt = (m_cnt + 1) % 256;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", longint'(out_valid), longint'(m_valid));
            chk("in_ready", longint'(in_ready), longint'(m_beat != 2));
            chk("state", longint'(state), longint'(m_beat == 0));
            chk("res_cnt", longint'(res_cnt), longint'(m_cnt));
            for (int k = 0; k < MD; k++) begin
                chk("re_elem", res(re_out, k), m_re[k]);
                chk("im_elem", res(im_out, k), m_im[k]);
            end
        end
    end

    task automatic load(input longint x0, input longint y0);
        logic [63:0] xv, yv;
        xv = x0; yv = y0;
        px[PL-1:0] = xv[PL-1:0];
        py[PL-1:0] = yv[PL-1:0];
        for (int k = 1; k < MD; k++) begin
            px[k*PL +: PL] = $urandom;
            py[k*PL +: PL] = $urandom;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] cnt0;
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        px = '0; py = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_state", longint'(state), 1);
        chk("rst_res_cnt", longint'(res_cnt), 0);
        chk("rst_re", longint'(re_out == '0), 1);
        chk("rst_im", longint'(im_out == '0), 1);
        cyc(); cyc();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Basic pass
        out_ready = 1'b1; in_valid = 1'b1; load(6, 2);
        cyc(); load(3, 4);
        cyc(); in_valid = 1'b0;
        chk("basic_re0", res(re_out, 0), 4);
        chk("basic_im0", res(im_out, 0), 7);
        chk("basic_valid", longint'(out_valid), 1);
        cyc();
        chk("basic_cnt", longint'(res_cnt), 1);
        chk("basic_valid_drop", longint'(out_valid), 0);

        // Extremes: no wrap in the 33-bit results
        in_valid = 1'b1; load(-64'sd2147483648, 64'sd2147483647);
        cyc(); load(64'sd2147483647, 64'sd2147483647);
        cyc(); in_valid = 1'b0;
        chk("ext_re0", res(re_out, 0), -64'sd4294967295);
        chk("ext_im0", res(im_out, 0), 64'sd4294967294);
        cyc();
        chk("ext_cnt", longint'(res_cnt), 2);

        // Backpressure with in_valid held high
        out_ready = 1'b0; in_valid = 1'b1; load(100, -50);
        cyc(); load(-7, 9);
        cyc();
        for (int i = 0; i < 5; i++) begin
            load($urandom_range(0, 1000), $urandom_range(0, 1000));
            cyc();
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_state", longint'(state), 0);
            chk("bp_re0", res(re_out, 0), 150);
            chk("bp_im0", res(im_out, 0), 2);
        end
        out_ready = 1'b1;
        cyc(); in_valid = 1'b0;
        chk("bp_cnt", longint'(res_cnt), 3);
        chk("bp_state_real", longint'(state), 1);
        cyc();
        chk("bp_single_hs", longint'(res_cnt), 3);

        // clr during the IMAG beat
        in_valid = 1'b1; load(20, 5);
        cyc(); clr = 1'b1; load(1, 1);
        cyc(); clr = 1'b0;
        chk("clr_valid", longint'(out_valid), 0);
        chk("clr_state", longint'(state), 1);
        chk("clr_cnt", longint'(res_cnt), 3);
        load(10, 3);
        cyc(); load(2, 2);
        chk("clr_re_as_real", res(re_out, 0), 7);
        cyc(); in_valid = 1'b0;
        chk("clr_im0", res(im_out, 0), 4);
        cyc();
        chk("clr_cnt_after", longint'(res_cnt), 4);

        // 256 back-to-back passes: counter wraps to its starting value
        cnt0 = res_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 256 * 3; i++) begin
            load($urandom, $urandom);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("wrap_cnt", longint'(res_cnt), longint'(cnt0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
